// File: rtl/pwm_duty_decoder.sv
// Recovers the duty cycle of an incoming PWM line in percent and classifies it
// into the 2-bit heating level code (00 LOW, 01 MEDIUM, 10 NORMAL, 11 HIGH).
module pwm_duty_decoder #(
  parameter int MAX_PERIOD = 50000000,
  parameter int CNT_BITS   = $clog2(MAX_PERIOD + 1)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       pwmIn,
  output logic [6:0] dutyPercent,
  output logic [1:0] heatingLevel,
  output logic       valid,
  output logic       stuck,
  output logic       overrun
);
  localparam int DW      = CNT_BITS + 7;
  localparam int IT_BITS = $clog2(DW + 1);
  localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_PERIOD);
  localparam logic [CNT_BITS-1:0] ONE     = CNT_BITS'(1);
  localparam logic [IT_BITS-1:0]  IT_LOAD = IT_BITS'(DW);
  localparam logic [IT_BITS-1:0]  IT_LAST = IT_BITS'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, MEAS_HIGH = 2'd1, MEAS_LOW = 2'd2} state_t;

  function automatic logic [1:0] classify(input logic [6:0] q);
    if (q < 7'd20)      return 2'b00;
    else if (q < 7'd40) return 2'b01;
    else if (q < 7'd65) return 2'b10;
    else                return 2'b11;
  endfunction

  logic                sync_q, s_q, s_dly_q;
  state_t              state_q;
  logic [CNT_BITS-1:0] cnt_q, h_q, p_q;
  logic                busy_q;
  logic [IT_BITS-1:0]  it_q;
  logic [CNT_BITS-1:0] rem_q, dvs_q, rem_d;
  logic [DW-1:0]       dvd_q, dvd_d, dividend_s;
  logic [CNT_BITS:0]   trial_s;
  logic                ge_s;
  logic [6:0]          duty_q;
  logic [1:0]          level_q;
  logic                valid_q, stuck_q, overrun_q, to_pend_q, to_hi_q;
  logic                rise_s, fall_s, timeout_s, close_s, div_done_s;

  assign rise_s     = s_q & ~s_dly_q;
  assign fall_s     = ~s_q & s_dly_q;
  assign timeout_s  = enable & (((state_q == IDLE) & ~rise_s & (cnt_q == MAX_CNT)) |
                                ((state_q != IDLE) & (p_q == MAX_CNT)));
  assign close_s    = enable & (state_q == MEAS_LOW) & rise_s & (p_q != MAX_CNT);
  assign div_done_s = enable & busy_q & (it_q == IT_LAST);
  assign dividend_s = DW'(h_q) * DW'(7'd100);

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial_s = {rem_q, dvd_q[DW-1]};
    ge_s    = (trial_s >= {1'b0, dvs_q});
    if (ge_s) begin
      rem_d = CNT_BITS'(trial_s - {1'b0, dvs_q});
    end else begin
      rem_d = trial_s[CNT_BITS-1:0];
    end
    dvd_d = {dvd_q[DW-2:0], ge_s};
  end

  // Two-flop synchronizer plus edge-detect register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= 1'b0;
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      sync_q  <= pwmIn;
      s_q     <= sync_q;
      s_dly_q <= s_q;
    end
  end

  // Measurement FSM; the closing rise doubles as the opening rise of the next period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      h_q     <= '0;
      p_q     <= '0;
    end else if (!enable) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      h_q     <= '0;
      p_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_s) begin
            h_q     <= ONE;
            p_q     <= ONE;
            cnt_q   <= '0;
            state_q <= MEAS_HIGH;
          end else if (cnt_q == MAX_CNT) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        MEAS_HIGH: begin
          if (p_q == MAX_CNT) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            h_q     <= '0;
            p_q     <= '0;
          end else if (fall_s) begin
            p_q     <= p_q + ONE;
            state_q <= MEAS_LOW;
          end else begin
            h_q <= h_q + ONE;
            p_q <= p_q + ONE;
          end
        end
        MEAS_LOW: begin
          if (p_q == MAX_CNT) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            h_q     <= '0;
            p_q     <= '0;
          end else if (rise_s) begin
            h_q     <= ONE;
            p_q     <= ONE;
            state_q <= MEAS_HIGH;
          end else begin
            p_q <= p_q + ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          h_q     <= '0;
          p_q     <= '0;
        end
      endcase
    end
  end

  // Divider sequencing: load on an accepted close, DW iterations, then idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      it_q   <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
    end else if (!enable) begin
      busy_q <= 1'b0;
      it_q   <= '0;
    end else if (busy_q) begin
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      it_q  <= it_q - IT_LAST;
      if (it_q == IT_LAST) begin
        busy_q <= 1'b0;
      end else begin
        busy_q <= 1'b1;
      end
    end else if (close_s) begin
      busy_q <= 1'b1;
      it_q   <= IT_LOAD;
      rem_q  <= '0;
      dvd_q  <= dividend_s;
      dvs_q  <= p_q;
    end else begin
      busy_q <= 1'b0;
    end
  end

  // A period closing while the divider is busy is dropped and flagged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= close_s & busy_q;
    end
  end

  // Result register: a divider result wins a collision, the timeout report follows a cycle later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      duty_q    <= 7'd0;
      level_q   <= 2'b00;
      valid_q   <= 1'b0;
      stuck_q   <= 1'b0;
      to_pend_q <= 1'b0;
      to_hi_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!enable) begin
        to_pend_q <= 1'b0;
      end else if (div_done_s) begin
        duty_q  <= dvd_d[6:0];
        level_q <= classify(dvd_d[6:0]);
        stuck_q <= 1'b0;
        valid_q <= 1'b1;
        if (timeout_s) begin
          to_pend_q <= 1'b1;
          to_hi_q   <= s_q;
        end else begin
          to_pend_q <= 1'b0;
        end
      end else if (to_pend_q) begin
        duty_q    <= to_hi_q ? 7'd100 : 7'd0;
        level_q   <= to_hi_q ? 2'b11 : 2'b00;
        stuck_q   <= 1'b1;
        valid_q   <= 1'b1;
        to_pend_q <= 1'b0;
      end else if (timeout_s) begin
        duty_q  <= s_q ? 7'd100 : 7'd0;
        level_q <= s_q ? 2'b11 : 2'b00;
        stuck_q <= 1'b1;
        valid_q <= 1'b1;
      end else begin
        to_pend_q <= 1'b0;
      end
    end
  end

  assign dutyPercent  = duty_q;
  assign heatingLevel = level_q;
  assign valid        = valid_q;
  assign stuck        = stuck_q;
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: a timestamp-based reference model of the decoder is
// compared with the DUT every cycle, with literal expectations at scenario ends.
module tb_pwm_duty_decoder;
  localparam int MAXP    = 1000;
  localparam int DIV_LAT = 18;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       pwmIn = 1'b0;
  logic [6:0] dutyPercent;
  logic [1:0] heatingLevel;
  logic       valid, stuck, overrun;

  pwm_duty_decoder #(.MAX_PERIOD(MAXP)) dut (
    .clock(clock), .reset(reset), .enable(enable), .pwmIn(pwmIn),
    .dutyPercent(dutyPercent), .heatingLevel(heatingLevel),
    .valid(valid), .stuck(stuck), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  // reference model state: event timestamps instead of counters
  int cyc = 0;
  bit m_sync1, m_s, m_sdly;
  bit m_meas;
  int t_rise, t_fall, idle_start;
  bit div_active;
  int div_close, div_q;
  bit to_pend, to_hi;
  int exp_duty, exp_level;
  bit exp_valid, exp_stuck, exp_over;

  // observed DUT results
  int last_duty = -1, last_level = -1, last_stuck = -1;
  int nvalid = 0, nover = 0;

  function automatic int lvl(int q);
    if (q < 20) return 0;
    if (q < 40) return 1;
    if (q < 65) return 2;
    return 3;
  endfunction

  task automatic report_timeout(bit hi);
    exp_duty  = hi ? 100 : 0;
    exp_level = hi ? 3 : 0;
    exp_stuck = 1'b1;
    exp_valid = 1'b1;
  endtask

  task automatic model_step();
    bit rise, fall, tmo, close, done;
    int hh, pp, dq;
    rise = m_s & ~m_sdly;
    fall = ~m_s & m_sdly;
    tmo = 1'b0; close = 1'b0; hh = 0; pp = 0;
    exp_valid = 1'b0;
    exp_over  = 1'b0;
    if (!reset) begin
      m_meas = 1'b0; div_active = 1'b0; to_pend = 1'b0;
      exp_duty = 0; exp_level = 0; exp_stuck = 1'b0;
      idle_start = cyc + 1;
      m_sync1 = 1'b0; m_s = 1'b0; m_sdly = 1'b0;
    end else begin
      if (!enable) begin
        m_meas = 1'b0; div_active = 1'b0; to_pend = 1'b0;
        idle_start = cyc + 1;
      end else begin
        if (!m_meas) begin
          if (rise) begin m_meas = 1'b1; t_rise = cyc; end
          else if (cyc - idle_start == MAXP) tmo = 1'b1;
        end else if (cyc - t_rise == MAXP) tmo = 1'b1;
        else if (rise) begin
          close = 1'b1; hh = t_fall - t_rise; pp = cyc - t_rise; t_rise = cyc;
        end else if (fall) t_fall = cyc;
        if (tmo) begin m_meas = 1'b0; idle_start = cyc + 1; end
        done = div_active && (cyc == div_close + DIV_LAT - 1);
        dq = div_q;
        if (close && div_active) exp_over = 1'b1;
        if (done) div_active = 1'b0;
        if (close && !exp_over) begin
          div_active = 1'b1; div_close = cyc; div_q = (hh * 100) / pp;
        end
        if (done) begin
          exp_duty = dq; exp_level = lvl(dq); exp_stuck = 1'b0; exp_valid = 1'b1;
          if (tmo) begin to_pend = 1'b1; to_hi = m_s; end
        end else if (to_pend) begin
          report_timeout(to_hi); to_pend = 1'b0;
        end else if (tmo) begin
          report_timeout(m_s);
        end
      end
      m_sdly = m_s; m_s = m_sync1; m_sync1 = pwmIn;
    end
    cyc++;
  endtask

  task automatic compare();
    checks++;
    if (int'(dutyPercent) == exp_duty && int'(heatingLevel) == exp_level &&
        valid === exp_valid && stuck === exp_stuck && overrun === exp_over) begin
      passes++;
    end else begin
      $display("FAIL cycle %0d outputs: got duty=%0d lvl=%0d valid=%0b stuck=%0b ovr=%0b, want duty=%0d lvl=%0d valid=%0b stuck=%0b ovr=%0b",
               cyc, dutyPercent, heatingLevel, valid, stuck, overrun,
               exp_duty, exp_level, exp_valid, exp_stuck, exp_over);
    end
    if (valid === 1'b1) begin
      last_duty = int'(dutyPercent); last_level = int'(heatingLevel);
      last_stuck = int'(stuck); nvalid++;
    end
    if (overrun === 1'b1) nover++;
  endtask

  task automatic pin(string name, int got, int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare();
  endtask

  task automatic hold(logic lv, int n);
    for (int i = 0; i < n; i++) begin pwmIn = lv; step(); end
  endtask

  task automatic run_pwm(int high, int period, int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < period; i++) begin pwmIn = (i < high); step(); end
  endtask

  int th[7] = '{19, 20, 39, 40, 64, 65, 99};
  int tl[7] = '{0, 1, 1, 2, 2, 3, 3};

  initial begin
    // reset with a toggling input
    for (int i = 0; i < 3; i++) begin pwmIn = logic'(i % 2); step(); end
    reset = 1'b1;
    pin("reset_duty", int'(dutyPercent), 0);
    pin("reset_flags", int'({valid, stuck, overrun, heatingLevel}), 0);

    // held low from reset -> one timeout report
    nvalid = 0;
    hold(1'b0, 1100);
    pin("low_timeout_count", nvalid, 1);
    pin("low_timeout_duty", last_duty, 0);
    pin("low_timeout_stuck", last_stuck, 1);
    pin("model_low_stuck", int'(exp_stuck), 1);

    nvalid = 0;
    run_pwm(30, 100, 4);
    pin("p30_count", nvalid, 3);
    pin("p30_duty", last_duty, 30);
    pin("p30_level", last_level, 1);
    pin("p30_stuck", last_stuck, 0);
    pin("model_p30", exp_duty, 30);

    nvalid = 0;
    run_pwm(80, 100, 4);
    pin("p80_count", nvalid, 4);
    pin("p80_duty", last_duty, 80);
    pin("p80_level", last_level, 3);

    for (int i = 0; i < 7; i++) begin
      run_pwm(th[i], 100, 3);
      pin("thr_duty", last_duty, th[i]);
      pin("thr_level", last_level, tl[i]);
    end

    hold(1'b0, 1100);
    pin("meas_low_timeout_duty", last_duty, 0);
    pin("meas_low_timeout_stuck", last_stuck, 1);

    // single 1/7 period, then idle low
    hold(1'b1, 1); hold(1'b0, 6); hold(1'b1, 1); hold(1'b0, 100);
    pin("p1of7_duty", last_duty, 14);
    pin("p1of7_level", last_level, 0);
    pin("p1of7_stuck", last_stuck, 0);

    hold(1'b0, 1100);
    hold(1'b1, 1200);
    pin("high_timeout_duty", last_duty, 100);
    pin("high_timeout_level", last_level, 3);
    pin("high_timeout_stuck", last_stuck, 1);

    // divider busy: every other close is dropped
    nvalid = 0; nover = 0;
    run_pwm(5, 10, 10);
    pin("busy_count", nvalid, 4);
    pin("busy_overruns", nover, 4);
    pin("busy_duty", last_duty, 50);
    pin("busy_level", last_level, 2);
    pin("busy_stuck", last_stuck, 0);

    // reset in the middle of the low phase
    run_pwm(40, 100, 3);
    hold(1'b1, 40); hold(1'b0, 30);
    reset = 1'b0;
    hold(1'b0, 2);
    reset = 1'b1;
    pin("midreset_duty", int'(dutyPercent), 0);
    nvalid = 0;
    hold(1'b0, 30);
    run_pwm(40, 100, 2);
    pin("after_reset_count", nvalid, 1);
    pin("after_reset_duty", last_duty, 40);

    // enable dropped while a result is in flight
    run_pwm(60, 100, 3);
    hold(1'b1, 10);
    nvalid = 0;
    enable = 1'b0;
    hold(1'b1, 20); hold(1'b0, 20);
    pin("disabled_count", nvalid, 0);
    pin("disabled_hold", int'(dutyPercent), 60);
    enable = 1'b1;
    hold(1'b0, 20);
    nvalid = 0;
    run_pwm(25, 100, 2);
    pin("resume_count", nvalid, 1);
    pin("resume_duty", last_duty, 25);

    // randomized periods, enables and stuck lines
    for (int r = 0; r < 25; r++) begin
      int per, hi, n, act;
      per = int'($urandom_range(300, 20));
      hi  = int'($urandom_range(per - 1, 1));
      n   = int'($urandom_range(4, 1));
      act = int'($urandom_range(5, 0));
      run_pwm(hi, per, n);
      if (act == 0) begin
        enable = 1'b0;
        hold(logic'($urandom_range(1, 0)), int'($urandom_range(60, 1)));
        enable = 1'b1;
      end else if (act == 1) begin
        hold(logic'($urandom_range(1, 0)), int'($urandom_range(1300, 50)));
      end
    end
    hold(1'b0, 40);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
- Receive-side counterpart of the heating PWM generator.
- Measures an incoming PWM waveform (pin or loopback of the generator output) and recovers the duty cycle in percent.
- Classifies the recovered duty into the 2-bit heatingLevel code (00 LOW, 01 MEDIUM, 10 NORMAL, 11 HIGH).
- Used for self-check of the heating path and for display feedback.

Parameters:
MAX_PERIOD, 50000000, timeout in clock cycles; no edge for this long means the line is stuck.
CNT_BITS, $clog2(MAX_PERIOD+1), counter width (derived; do not override).

Ports:
clock  input  1  system clock; all logic on posedge.
reset  input  1  asynchronous, active-low reset (0 = reset); one clock domain.
enable  input  1  1 = measure; 0 = hold FSM in IDLE, clear counters, outputs hold last value.
pwmIn  input  1  asynchronous PWM input.
dutyPercent  output  7  last measured duty, 0..100.
heatingLevel  output  2  classification of dutyPercent.
valid  output  1  one-cycle pulse when dutyPercent/heatingLevel update.
stuck  output  1  1 when the last update came from a timeout; cleared by the next normal update.
overrun  output  1  one-cycle pulse when a completed period is dropped because the divider is busy.

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM to IDLE, counters 0, divider idle, synchronizer flops 0. Reset mid-measurement discards the partial period.
- Input conditioning: 2-flop synchronizer to s, then edge registers. rise = s & ~s_d; fall = ~s & s_d. Timing is counted on s, so synchronizer delay does not change the measured duty.
- FSM states: IDLE, MEAS_HIGH, MEAS_LOW.
- IDLE:
  - cnt increments each cycle.
  - On rise: H=1, P=1, go to MEAS_HIGH.
  - On cnt==MAX_PERIOD: timeout report, level taken from s.
- MEAS_HIGH:
  - H++ and P++ each cycle while s=1.
  - On fall: P++, go to MEAS_LOW.
- MEAS_LOW:
  - P++ each cycle.
  - On rise: period closes. Hand (H,P) to the divider; the rise cycle is not counted. Restart with H=1, P=1 and stay MEAS_HIGH, so back-to-back periods are measured without gaps.
- Timeout: if P reaches MAX_PERIOD in MEAS_HIGH or MEAS_LOW, or cnt reaches it in IDLE:
  - Report duty 100/level 11 if s=1, or duty 0/level 00 if s=0.
  - Set stuck=1, pulse valid next cycle, go to IDLE with cnt=0.
  - Any divider result in flight is still delivered.
- Divider:
  - Restoring, 1 quotient bit per cycle.
  - Dividend H*100 is CNT_BITS+7 bits wide; divisor is P.
  - Quotient is floor(H*100/P), always ≤100, truncated to 7 bits.
  - Loaded the cycle after the closing rise.
  - Latency is fixed: valid asserts exactly DIV_LAT = CNT_BITS+8 cycles after the closing-rise cycle.
  - dutyPercent, heatingLevel and stuck=0 update on the same edge that raises valid.
- Busy divider: if a period closes while the divider is busy, the new (H,P) is dropped and overrun pulses for 1 cycle. The in-flight result completes normally.
- Simultaneous events: if a timeout report and a divider result fall on the same cycle, the divider result is presented first. The timeout report follows on the next cycle, so valid is high for 2 consecutive cycles.
- Classification, from the quotient q:
  - q<20 gives 00.
  - 20≤q<40 gives 01.
  - 40≤q<65 gives 10.
  - q≥65 gives 11.
- enable=0: state IDLE, cnt/H/P cleared, divider aborted with no valid, outputs held. Measurement resumes at the first rise after enable returns to 1.

Test Plan (MAX_PERIOD=1000, so CNT_BITS=10, DIV_LAT=18):
1. Reset low for 3 cycles while pwmIn toggles, then release -> dutyPercent=0, heatingLevel=00, valid/stuck/overrun=0; no valid before one full period has elapsed after the first rise.
2. Continuous PWM, high 30 / period 100 -> valid every 100 cycles, each 18 cycles after the closing rise; dutyPercent=30, heatingLevel=01. Change to high 80 / period 100 -> 80, 11. High 1 / period 7 (single period, then idle low) -> 14, 00.
3. Thresholds, period 100: high 19/20 -> 00/01; high 39/40 -> 01/10; high 64/65 -> 10/11; high 99 -> 99, 11.
4. pwmIn held high 1200 cycles after a rise -> valid with dutyPercent=100, 11, stuck=1 at the timeout. Held low from reset -> 0, 00, stuck=1. Next normal period clears stuck.
5. Continuous PWM, period 10 / high 5 -> first result 50/10; subsequent closes while the divider is busy pulse overrun; every delivered result equals 50.
6. Reset pulsed mid-MEAS_LOW, and separately enable deasserted mid-period -> no valid from the partial period; with enable, outputs hold their previous value and the first result after resume equals the first complete new period.
